// File: rtl/wordcnt_xfer_ctrl.sv
// wordcnt_xfer_ctrl: sequences one block transfer over an external 8-bit word counter and a bus req/ack handshake.
// Optional feature: define XFER_AUTORELOAD_EN to add the 'rpt' input (reload and repeat after done).
module wordcnt_xfer_ctrl #(
    parameter int W     = 8,
    parameter int TMO_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] len,
    input  logic         abort,
    input  logic         bus_ack,
    input  logic [W-1:0] cnt_q,
`ifdef XFER_AUTORELOAD_EN
    input  logic         rpt,
`endif
    output logic         cnt_pl,
    output logic         cnt_res,
    output logic         cnt_en,
    output logic         cnt_dec,
    output logic         cnt_inc,
    output logic         cnt_wci,
    output logic [W-1:0] cnt_data,
    output logic         bus_req,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic         tmo_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ABRT = 3'd4;

    // Last idle-count value before the (2**TMO_W-1)-th ack-less REQ cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0]     CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [2:0]       next_s;
    logic [W-1:0]     len_r;
    logic [TMO_W-1:0] tmo_r;
    logic             dec_s;
    logic             tmo_hit_s;
    logic             accept_s;
    logic             reload_s;
    logic             cnt_pl_r;
    logic             bus_req_r;
    logic             busy_r;
    logic             done_r;
    logic             abrt_r;
    logic             tmo_err_r;

`ifdef XFER_AUTORELOAD_EN
    assign reload_s = rpt;
`else
    assign reload_s = 1'b0;
`endif

    assign accept_s = (state_r == S_IDLE) && start;

    // Next-state decode; abort wins over ack, a zero counter in REQ is a protocol error.
    always_comb begin
        next_s    = state_r;
        dec_s     = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = (len != CNT_ZERO) ? S_LOAD : S_DONE;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                next_s = abort ? S_ABRT : S_REQ;
            end
            S_REQ: begin
                if (abort) begin
                    next_s = S_ABRT;
                end else if (cnt_q == CNT_ZERO) begin
                    next_s = S_ABRT;
                end else if (bus_ack) begin
                    dec_s  = 1'b1;
                    next_s = (cnt_q == CNT_ONE) ? S_DONE : S_REQ;
                end else if (tmo_r == TMO_LAST) begin
                    tmo_hit_s = 1'b1;
                    next_s    = S_ABRT;
                end else begin
                    next_s = S_REQ;
                end
            end
            S_DONE: begin
                if (abort) begin
                    next_s = S_ABRT;
                end else if (reload_s) begin
                    next_s = S_LOAD;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_ABRT: begin
                next_s = S_IDLE;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State, registered outputs decoded from the next state, saved length and ack timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            len_r     <= CNT_ZERO;
            tmo_r     <= {TMO_W{1'b0}};
            cnt_pl_r  <= 1'b0;
            bus_req_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            abrt_r    <= 1'b0;
            tmo_err_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            cnt_pl_r  <= (next_s == S_LOAD);
            bus_req_r <= (next_s == S_REQ);
            busy_r    <= (next_s != S_IDLE);
            done_r    <= (next_s == S_DONE);
            abrt_r    <= (next_s == S_ABRT);
            if (accept_s && (len != CNT_ZERO)) begin
                len_r <= len;
            end else begin
                len_r <= len_r;
            end
            if (accept_s) begin
                tmo_err_r <= 1'b0;
            end else if (tmo_hit_s) begin
                tmo_err_r <= 1'b1;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
            if ((state_r == S_REQ) && (next_s == S_REQ) && !dec_s) begin
                tmo_r <= tmo_r + TMO_ONE;
            end else begin
                tmo_r <= {TMO_W{1'b0}};
            end
        end
    end

    // The decrement must land on the ack cycle itself, so it bypasses the output registers.
    assign cnt_en   = dec_s && !rst;
    assign cnt_dec  = dec_s && !rst;
    assign cnt_res  = rst || abrt_r;
    assign cnt_inc  = 1'b0;
    assign cnt_wci  = 1'b0;
    assign cnt_data = len_r;
    assign cnt_pl   = cnt_pl_r;
    assign bus_req  = bus_req_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign aborted  = abrt_r;
    assign tmo_err  = tmo_err_r;

endmodule

// File: tb/tb_wordcnt_xfer_ctrl.sv
// Self-checking bench for wordcnt_xfer_ctrl: models the word counter and derives expected
// output timelines from word counts and ack patterns. Define XFER_AUTORELOAD_EN to test 'rpt'.
module tb_wordcnt_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, abort, bus_ack;
    logic [7:0] len;
    logic [7:0] cnt_q;
    logic [7:0] cnt_data;
    logic       cnt_pl, cnt_res, cnt_en, cnt_dec, cnt_inc, cnt_wci;
    logic       bus_req, busy, done, aborted, tmo_err;
`ifdef XFER_AUTORELOAD_EN
    logic       rpt = 1'b0;
`endif
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_dec = 0;
    logic tmo_exp = 1'b0;

    always #5 clk = ~clk;

    wordcnt_xfer_ctrl #(.W(8), .TMO_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .bus_ack(bus_ack), .cnt_q(cnt_q),
`ifdef XFER_AUTORELOAD_EN
        .rpt(rpt),
`endif
        .cnt_pl(cnt_pl), .cnt_res(cnt_res), .cnt_en(cnt_en), .cnt_dec(cnt_dec),
        .cnt_inc(cnt_inc), .cnt_wci(cnt_wci), .cnt_data(cnt_data), .bus_req(bus_req),
        .busy(busy), .done(done), .aborted(aborted), .tmo_err(tmo_err)
    );

    // Word counter model: reset beats load beats decrement.
    always @(posedge clk) begin
        if (cnt_res) begin
            cnt_q <= 8'd0;
        end else if (cnt_pl) begin
            cnt_q <= cnt_data;
        end else if (cnt_en && cnt_dec) begin
            cnt_q <= cnt_q - 8'd1;
            n_dec <= n_dec + 1;
        end
    end

    function automatic logic [10:0] outs();
        return {cnt_pl, cnt_res, cnt_en, cnt_dec, cnt_inc, cnt_wci, bus_req, busy, done, aborted, tmo_err};
    endfunction

    function automatic logic [10:0] exp_v(input logic pl, input logic res, input logic en, input logic req,
                                          input logic bsy, input logic dn, input logic ab, input logic tmo);
        return {pl, res, en, en, 1'b0, 1'b0, req, bsy, dn, ab, tmo};
    endfunction

    task automatic cyc(input logic r, input logic st, input logic [7:0] ln, input logic ab, input logic ack);
        @(negedge clk);
        rst = r; start = st; len = ln; abort = ab; bus_ack = ack;
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
            e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL reset i=%0d got %b want %b", i, outs(), e); end
        end
        tmo_exp = 1'b0;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== 11'd0) begin n_bad++; $display("FAIL reset_release got %b want %b", outs(), 11'd0); end
        n_cmp++;
        if (cnt_q !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt_q); end
    endtask

    task automatic test_full_ack(input int L);
        int d0;
        logic rq;
        logic [10:0] e;
        d0 = n_dec;
        for (int t = 0; t <= L + 3; t++) begin
            cyc(1'b0, t == 0, 8'(L), 1'b0, 1'b1);
            rq = (t >= 2) && (t <= L + 1);
            e = exp_v(t == 1, 1'b0, rq, rq, (t >= 1) && (t <= L + 2), t == L + 2, 1'b0, (t == 0) ? tmo_exp : 1'b0);
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL full_ack L=%0d t=%0d got %b want %b", L, t, outs(), e); end
            if (t == 1) begin
                n_cmp++;
                if (cnt_data !== 8'(L)) begin n_bad++; $display("FAIL full_ack_data got %0d want %0d", cnt_data, L); end
            end
            if (rq) begin
                n_cmp++;
                if (int'(cnt_q) !== L - (t - 2)) begin n_bad++; $display("FAIL full_ack_cnt t=%0d got %0d want %0d", t, cnt_q, L - (t - 2)); end
            end
        end
        tmo_exp = 1'b0;
        n_cmp++;
        if (n_dec - d0 !== L) begin n_bad++; $display("FAIL full_ack_decs got %0d want %0d", n_dec - d0, L); end
    endtask

    task automatic test_zero_len();
        int d0;
        logic [10:0] e;
        d0 = n_dec;
        for (int t = 0; t <= 2; t++) begin
            cyc(1'b0, t == 0, 8'd0, 1'b0, 1'b1);
            e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, t == 1, t == 1, 1'b0, (t == 0) ? tmo_exp : 1'b0);
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL zero_len t=%0d got %b want %b", t, outs(), e); end
        end
        tmo_exp = 1'b0;
        n_cmp++;
        if ((n_dec - d0 !== 0) || (cnt_q !== 8'd0)) begin n_bad++; $display("FAIL zero_len_cnt got decs=%0d q=%0d want 0/0", n_dec - d0, cnt_q); end
    endtask

    task automatic test_random_ack();
        int L, left, idle;
        logic ack;
        logic [10:0] e;
        L = int'($urandom_range(1, 24));
        left = L;
        idle = 0;
        cyc(1'b0, 1'b1, 8'(L), 1'b0, 1'($urandom_range(0, 1)));
        e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tmo_exp);
        n_cmp++;
        if (outs() !== e) begin n_bad++; $display("FAIL rnd_start got %b want %b", outs(), e); end
        tmo_exp = 1'b0;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'($urandom_range(0, 1)));
        e = exp_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== e || cnt_data !== 8'(L)) begin n_bad++; $display("FAIL rnd_load got %b/%0d want %b/%0d", outs(), cnt_data, e, L); end
        while (left > 0) begin
            ack = (idle >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, ack);
            e = exp_v(1'b0, 1'b0, ack, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (outs() !== e || int'(cnt_q) !== left) begin
                n_bad++; $display("FAIL rnd_req left=%0d got %b/%0d want %b/%0d", left, outs(), cnt_q, e, left);
            end
            if (ack) begin left--; idle = 0; end else idle++;
        end
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'($urandom_range(0, 1)));
        e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== e) begin n_bad++; $display("FAIL rnd_done got %b want %b", outs(), e); end
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== 11'd0) begin n_bad++; $display("FAIL rnd_idle got %b want %b", outs(), 11'd0); end
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        for (int t = 0; t <= 18; t++) begin
            cyc(1'b0, t == 0, 8'd4, 1'b0, 1'b0);
            if (t == 0)       e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tmo_exp);
            else if (t == 1)  e = exp_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t <= 16) e = exp_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 17) e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            else              e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL timeout t=%0d got %b want %b", t, outs(), e); end
        end
        tmo_exp = 1'b1;
        n_cmp++;
        if (cnt_q !== 8'd0) begin n_bad++; $display("FAIL timeout_cnt got %0d want 0", cnt_q); end
    endtask

    // 14 silent cycles before each ack must not time out; the new start clears tmo_err.
    task automatic test_tmo_boundary();
        logic [10:0] e;
        cyc(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tmo_exp);
        n_cmp++;
        if (outs() !== e) begin n_bad++; $display("FAIL tmo_bnd_start got %b want %b", outs(), e); end
        tmo_exp = 1'b0;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i <= 14; i++) begin
                cyc(1'b0, 1'b0, 8'd0, 1'b0, i == 14);
                e = exp_v(1'b0, 1'b0, i == 14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                n_cmp++;
                if (outs() !== e) begin n_bad++; $display("FAIL tmo_bnd w=%0d i=%0d got %b want %b", w, i, outs(), e); end
            end
        end
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== e) begin n_bad++; $display("FAIL tmo_bnd_done got %b want %b", outs(), e); end
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_abort_ack();
        int d0;
        logic [10:0] e;
        d0 = n_dec;
        for (int t = 0; t <= 5; t++) begin
            cyc(1'b0, t == 0, 8'd5, t == 3, 1'b1);
            if (t <= 1)      e = exp_v(t == 1, 1'b0, 1'b0, 1'b0, t == 1, 1'b0, 1'b0, 1'b0);
            else if (t <= 3) e = exp_v(1'b0, 1'b0, t == 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 4) e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else             e = 11'd0;
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL abort_ack t=%0d got %b want %b", t, outs(), e); end
            if (t == 4) begin
                n_cmp++;
                if (cnt_q !== 8'd4) begin n_bad++; $display("FAIL abort_ack_cnt got %0d want 4", cnt_q); end
            end
        end
        n_cmp++;
        if (n_dec - d0 !== 1 || cnt_q !== 8'd0) begin n_bad++; $display("FAIL abort_ack_end got decs=%0d q=%0d want 1/0", n_dec - d0, cnt_q); end
    endtask

    task automatic test_abort_phases();
        int L;
        logic [10:0] e;
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        n_cmp++;
        if (outs() !== 11'd0) begin n_bad++; $display("FAIL abort_idle got %b want %b", outs(), 11'd0); end
        L = int'($urandom_range(1, 9));
        for (int t = 0; t <= 3; t++) begin
            cyc(1'b0, t == 0, 8'(L), t == 1, 1'b1);
            if (t == 0)      e = 11'd0;
            else if (t == 1) e = exp_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 2) e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else             e = 11'd0;
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL abort_load t=%0d got %b want %b", t, outs(), e); end
        end
        for (int t = 0; t <= 5; t++) begin
            cyc(1'b0, t == 0, 8'd1, t == 3, 1'b1);
            if (t <= 1)      e = exp_v(t == 1, 1'b0, 1'b0, 1'b0, t == 1, 1'b0, 1'b0, 1'b0);
            else if (t == 2) e = exp_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 3) e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (t == 4) e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else             e = 11'd0;
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL abort_done t=%0d got %b want %b", t, outs(), e); end
        end
    endtask

    task automatic test_rst_mid();
        logic [10:0] e;
        for (int t = 0; t <= 11; t++) begin
            cyc(t == 4, (t == 0) || (t == 5), (t == 5) ? 8'd3 : 8'd4, 1'b0, t != 5);
            if (t <= 1)       e = exp_v(t == 1, 1'b0, 1'b0, 1'b0, t == 1, 1'b0, 1'b0, 1'b0);
            else if (t <= 3)  e = exp_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 4)  e = exp_v(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 5)  e = 11'd0;
            else if (t == 6)  e = exp_v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t <= 9)  e = exp_v(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 10) e = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            else              e = 11'd0;
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL rst_mid t=%0d got %b want %b", t, outs(), e); end
            if (t == 4 || t == 5 || t == 6) begin
                n_cmp++;
                if (cnt_q !== ((t == 4) ? 8'd2 : 8'd0)) begin n_bad++; $display("FAIL rst_mid_cnt t=%0d got %0d want %0d", t, cnt_q, (t == 4) ? 2 : 0); end
            end
        end
    endtask

`ifdef XFER_AUTORELOAD_EN
    task automatic test_autoreload();
        int p;
        logic [10:0] e;
        rpt = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            cyc(1'b0, t == 0, 8'd2, t == 10, 1'b1);
            p = (t - 1) % 4;
            if (t == 0)       e = 11'd0;
            else if (t == 10) e = exp_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (t == 11) e = exp_v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else if (t == 12) e = 11'd0;
            else              e = exp_v(p == 0, 1'b0, (p == 1) || (p == 2), (p == 1) || (p == 2), 1'b1, p == 3, 1'b0, 1'b0);
            n_cmp++;
            if (outs() !== e) begin n_bad++; $display("FAIL autoreload t=%0d got %b want %b", t, outs(), e); end
        end
        rpt = 1'b0;
        n_cmp++;
        if (cnt_q !== 8'd0) begin n_bad++; $display("FAIL autoreload_cnt got %0d want 0", cnt_q); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; bus_ack = 1'b0;
        test_reset();
        test_full_ack(3);
        test_full_ack(1);
        test_full_ack(int'($urandom_range(2, 40)));
        test_zero_len();
        for (int i = 0; i < 6; i++) test_random_ack();
        test_timeout();
        test_tmo_boundary();
        test_abort_ack();
        test_abort_phases();
        test_rst_mid();
`ifdef XFER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
